// File: rtl/fsm_jk_gray2_pkg.sv
// Shared types and constants for the two-bit JK Gray-code sequencer.
// State codes follow the Gray cycle S0 -> S1 -> S2 -> S3 -> S0.
`timescale 1ns/100ps
package fsm_jk_gray2_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S0 = 2'b00;
   localparam state_t S1 = 2'b01;
   localparam state_t S2 = 2'b11;
   localparam state_t S3 = 2'b10;

   // JK operation codes, indexed by {j,k}
   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] CLR  = 2'b01;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] TGL  = 2'b11;

   // Next value of a single JK flop
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic nq;
      nq = q;
      case ({j, k})
         HOLD:    nq = q;
         CLR:     nq = 1'b0;
         SET:     nq = 1'b1;
         TGL:     nq = ~q;
         default: nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/fsm_jk_gray2_jk_ff.sv
// Single JK flip-flop with asynchronous active-low reset to RESET_VAL.
`timescale 1ns/100ps
module jk_ff
   import fsm_jk_gray2_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   // Reset loads RESET_VAL at once; otherwise apply the JK rule on each rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VAL;
      end else begin
         q <= jk_next(q, j, k);
      end
   end

endmodule

// File: rtl/fsm_jk_gray2.sv
// Two-bit Moore Gray-code sequencer (00 -> 01 -> 11 -> 10 -> 00) built from two JK flops.
// Optional feature macro: FSM_JK_GRAY2_HOLD_EN adds an `en` input; en=0 forces J=K=0
// on both flops so the state holds.
//
//   state | meaning
//   S0=00 | first code, default reset code
//   S1=01 | second code
//   S2=11 | third code
//   S3=10 | fourth code, wraps to S0
`timescale 1ns/100ps
module fsm_jk_gray2
   import fsm_jk_gray2_pkg::*;
#(
   parameter state_t RESET_STATE = S0
) (
   input  logic       clk,
   input  logic       rst,
`ifdef FSM_JK_GRAY2_HOLD_EN
   input  logic       en,
`endif
   output logic [1:0] Salida
);

   logic q0;
   logic q1;
   logic j0;
   logic k0;
   logic j1;
   logic k1;
   logic adv;

`ifdef FSM_JK_GRAY2_HOLD_EN
   assign adv = en;
`else
   assign adv = 1'b1;
`endif

   // Excitation logic; a deasserted advance turns both flops into HOLD
   always_comb begin
      j0 = adv & ~q1;
      k0 = adv &  q1;
      j1 = adv &  q0;
      k1 = adv & ~q0;
   end

   jk_ff #(.RESET_VAL(RESET_STATE[0])) u_ff0 (
      .clk   (clk),
      .rst_n (rst),
      .j     (j0),
      .k     (k0),
      .q     (q0)
   );

   jk_ff #(.RESET_VAL(RESET_STATE[1])) u_ff1 (
      .clk   (clk),
      .rst_n (rst),
      .j     (j1),
      .k     (k1),
      .q     (q1)
   );

   assign Salida = {q1, q0};

endmodule

// File: tb/tb_fsm_jk_gray2.sv
// Bench for fsm_jk_gray2: two instances (reset code 00 and 10) checked against a
// sequence-table model every cycle, plus hand-computed directed expectations.
`timescale 1ns/100ps
module tb_fsm_jk_gray2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [1:0] salida_a;
   logic [1:0] salida_b;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   logic [1:0] gray_seq [4];
   int idx_a = 0;
   int idx_b = 3;

   always #1 clk = ~clk;

   fsm_jk_gray2 #(.RESET_STATE(2'b00)) dut_a (
      .clk    (clk),
      .rst    (rst),
`ifdef FSM_JK_GRAY2_HOLD_EN
      .en     (en),
`endif
      .Salida (salida_a)
   );

   fsm_jk_gray2 #(.RESET_STATE(2'b10)) dut_b (
      .clk    (clk),
      .rst    (rst),
`ifdef FSM_JK_GRAY2_HOLD_EN
      .en     (en),
`endif
      .Salida (salida_b)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic en_eff();
`ifdef FSM_JK_GRAY2_HOLD_EN
      return en;
`else
      return 1'b1;
`endif
   endfunction

   initial begin
      gray_seq[0] = 2'b00;
      gray_seq[1] = 2'b01;
      gray_seq[2] = 2'b11;
      gray_seq[3] = 2'b10;
   end

   // Model: position in the Gray table; reset returns to each instance's start code
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_a = 0;
         idx_b = 3;
      end else if (en_eff()) begin
         idx_a = (idx_a + 1) % 4;
         idx_b = (idx_b + 1) % 4;
      end
   end

   // Compare both instances against the model away from the active edge
   always @(negedge clk) begin
      if (cmp_on) begin
         check("model_a", int'(salida_a), int'(gray_seq[idx_a]));
         check("model_b", int'(salida_b), int'(gray_seq[idx_b]));
      end
   end

   initial begin
      logic [1:0] exp_a [8];
      logic [1:0] exp_b [8];
      logic [1:0] prev;
      int         guard;
      exp_a = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
      exp_b = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};

      // Reset held across two edges
      rst = 1'b0;
      @(posedge clk); #0.5;
      cmp_on = 1'b1;
      check("reset_a_edge1", int'(salida_a), 0);
      check("reset_b_edge1", int'(salida_b), 2);
      @(posedge clk); #0.5;
      check("reset_a_edge2", int'(salida_a), 0);
      check("reset_b_edge2", int'(salida_b), 2);

      // Release between edges; sequence with wrap-around
      @(negedge clk); #0.5;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #0.5;
         check($sformatf("seq_a_%0d", i), int'(salida_a), int'(exp_a[i]));
         check($sformatf("seq_b_%0d", i), int'(salida_b), int'(exp_b[i]));
      end

      // Gray property over 50 edges
      for (int i = 0; i < 50; i++) begin
         prev = salida_a;
         @(posedge clk); #0.5;
         check($sformatf("gray_%0d", i), $countones(salida_a ^ prev), 1);
      end

      // Advance to 11, then assert reset between edges
      guard = 0;
      while (salida_a !== 2'b11 && guard < 8) begin
         @(posedge clk); #0.5;
         guard++;
      end
      check("reach_11", int'(salida_a), 3);
      rst = 1'b0;
      #0.3;
      check("async_rst_a", int'(salida_a), 0);
      check("async_rst_b", int'(salida_b), 2);
      @(posedge clk); #0.5;
      check("async_hold_a", int'(salida_a), 0);

      @(negedge clk); #0.5;
      rst = 1'b1;
      @(posedge clk); #0.5;
      check("post_rst_a", int'(salida_a), 1);
      check("post_rst_b", int'(salida_b), 0);

`ifdef FSM_JK_GRAY2_HOLD_EN
      // Hold at 01 for three edges, then resume
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #0.5;
         check($sformatf("hold_a_%0d", i), int'(salida_a), 1);
      end
      en = 1'b1;
      @(posedge clk); #0.5;
      check("resume_a", int'(salida_a), 3);
`endif

      @(negedge clk); #0.5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
